// File: rtl/proc_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | proc_pkg                                                           |
// | Shared processor widths and the hard-wired zero register index.    |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
package proc_pkg;
    localparam int DATA_WIDTH = 32;
    localparam int ADDR_WIDTH = 5;
    localparam int TAG_WIDTH  = 8;
    localparam int ZERO_REG   = 0;
endpackage
`default_nettype wire

// File: rtl/opfetch_fwd_mux.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | opfetch_fwd_mux                                                    |
// | Per-operand select: zero register / snooped write / register file. |
// | Build macro: OPFETCH_BYPASS_EN enables the snooped-write path.     |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module opfetch_fwd_mux #(
    parameter int DATA_WIDTH = proc_pkg::DATA_WIDTH,
    parameter int ADDR_WIDTH = proc_pkg::ADDR_WIDTH
) (
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [DATA_WIDTH-1:0] rf_data_i,
    input  logic                  wb_wena_i,
    input  logic [ADDR_WIDTH-1:0] wb_waddr_i,
    input  logic [DATA_WIDTH-1:0] wb_wdata_i,
    output logic [DATA_WIDTH-1:0] operand_o
);
    import proc_pkg::*;

    logic w_is_zero;
    assign w_is_zero = (addr_i == ADDR_WIDTH'(ZERO_REG));

`ifdef OPFETCH_BYPASS_EN
    logic w_hit;
    assign w_hit = wb_wena_i && (wb_waddr_i == addr_i);

    // Zero check first so writes to register 0 are never forwarded.
    always_comb begin
        if (w_is_zero) begin
            operand_o = '0;
        end else if (w_hit) begin
            operand_o = wb_wdata_i;
        end else begin
            operand_o = rf_data_i;
        end
    end
`else
    logic w_unused_wb;
    assign w_unused_wb = ^{wb_wena_i, wb_waddr_i, wb_wdata_i};

    always_comb begin
        if (w_is_zero) begin
            operand_o = '0;
        end else begin
            operand_o = rf_data_i;
        end
    end
`endif
endmodule
`default_nettype wire

// File: rtl/operand_fetch.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | operand_fetch                                                      |
// | Register-file read stage with a single output entry for execute.   |
// | Build macro: OPFETCH_BYPASS_EN enables write snooping/forwarding.  |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module operand_fetch #(
    parameter int DATA_WIDTH = proc_pkg::DATA_WIDTH,
    parameter int ADDR_WIDTH = proc_pkg::ADDR_WIDTH,
    parameter int TAG_WIDTH  = proc_pkg::TAG_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [ADDR_WIDTH-1:0] in_r0addr,
    input  logic [ADDR_WIDTH-1:0] in_r1addr,
    input  logic [TAG_WIDTH-1:0]  in_tag,
    output logic [ADDR_WIDTH-1:0] rf_r0addr,
    output logic [ADDR_WIDTH-1:0] rf_r1addr,
    input  logic [DATA_WIDTH-1:0] rf_r0data,
    input  logic [DATA_WIDTH-1:0] rf_r1data,
    input  logic                  wb_wena,
    input  logic [ADDR_WIDTH-1:0] wb_waddr,
    input  logic [DATA_WIDTH-1:0] wb_wdata,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_op0,
    output logic [DATA_WIDTH-1:0] out_op1,
    output logic [TAG_WIDTH-1:0]  out_tag
);
    import proc_pkg::*;

    logic                  out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0] op0_q, op0_d;
    logic [DATA_WIDTH-1:0] op1_q, op1_d;
    logic [TAG_WIDTH-1:0]  tag_q, tag_d;
    logic [ADDR_WIDTH-1:0] src0_q, src0_d;
    logic [ADDR_WIDTH-1:0] src1_q, src1_d;
    logic [DATA_WIDTH-1:0] w_sel0, w_sel1;
    logic                  w_accept;

    assign rf_r0addr = in_r0addr;
    assign rf_r1addr = in_r1addr;

    // rst term keeps the stage advertising ready while reset is held.
    assign in_ready = !flush && (rst || !out_valid_q || out_ready);
    assign w_accept = in_valid && in_ready;

    opfetch_fwd_mux #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) u_mux0 (
        .addr_i     (in_r0addr),
        .rf_data_i  (rf_r0data),
        .wb_wena_i  (wb_wena),
        .wb_waddr_i (wb_waddr),
        .wb_wdata_i (wb_wdata),
        .operand_o  (w_sel0)
    );

    opfetch_fwd_mux #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) u_mux1 (
        .addr_i     (in_r1addr),
        .rf_data_i  (rf_r1data),
        .wb_wena_i  (wb_wena),
        .wb_waddr_i (wb_waddr),
        .wb_wdata_i (wb_wdata),
        .operand_o  (w_sel1)
    );

`ifdef OPFETCH_BYPASS_EN
    logic w_hold_hit0, w_hold_hit1;
    assign w_hold_hit0 = wb_wena && (wb_waddr == src0_q) && (src0_q != ADDR_WIDTH'(ZERO_REG));
    assign w_hold_hit1 = wb_wena && (wb_waddr == src1_q) && (src1_q != ADDR_WIDTH'(ZERO_REG));
`else
    logic w_unused_src;
    assign w_unused_src = ^{src0_q, src1_q};
`endif

    always_comb begin
        out_valid_d = out_valid_q;
        op0_d       = op0_q;
        op1_d       = op1_q;
        tag_d       = tag_q;
        src0_d      = src0_q;
        src1_d      = src1_q;
        if (flush) begin
            out_valid_d = 1'b0;
        end else if (w_accept) begin
            out_valid_d = 1'b1;
            op0_d       = w_sel0;
            op1_d       = w_sel1;
            tag_d       = in_tag;
            src0_d      = in_r0addr;
            src1_d      = in_r1addr;
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
`ifdef OPFETCH_BYPASS_EN
        end else if (out_valid_q) begin
            // Held entry tracks writes to its sources so it never goes stale.
            if (w_hold_hit0) begin
                op0_d = wb_wdata;
            end
            if (w_hold_hit1) begin
                op1_d = wb_wdata;
            end
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            op0_q       <= '0;
            op1_q       <= '0;
            tag_q       <= '0;
            src0_q      <= '0;
            src1_q      <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            op0_q       <= op0_d;
            op1_q       <= op1_d;
            tag_q       <= tag_d;
            src0_q      <= src0_d;
            src1_q      <= src1_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_op0   = op0_q;
    assign out_op1   = op1_q;
    assign out_tag   = tag_q;
endmodule
`default_nettype wire

// File: tb/tb_operand_fetch.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_operand_fetch                                                   |
// | Directed bench for operand_fetch with a small register file model. |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module tb_operand_fetch;
`ifdef OPFETCH_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, in_ready, out_valid, out_ready, wb_wena;
    logic [4:0]  in_r0addr, in_r1addr, rf_r0addr, rf_r1addr, wb_waddr;
    logic [7:0]  in_tag, out_tag;
    logic [31:0] rf_r0data, rf_r1data, wb_wdata, out_op0, out_op1;
    logic [31:0] rf [0:31];
    logic [31:0] exp_op0 [1:4];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    // Register file model: written on posedge, read combinationally.
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) rf[i] <= 32'h100 + i;
            rf[0] <= 32'hDEAD;
            rf[3] <= 32'h33;
            rf[5] <= 32'h11;
            rf[7] <= 32'h77;
        end else if (wb_wena) begin
            rf[wb_waddr] <= wb_wdata;
        end
    end
    assign rf_r0data = rf[rf_r0addr];
    assign rf_r1data = rf[rf_r1addr];

    operand_fetch dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_r0addr (in_r0addr),
        .in_r1addr (in_r1addr),
        .in_tag    (in_tag),
        .rf_r0addr (rf_r0addr),
        .rf_r1addr (rf_r1addr),
        .rf_r0data (rf_r0data),
        .rf_r1data (rf_r1data),
        .wb_wena   (wb_wena),
        .wb_waddr  (wb_waddr),
        .wb_wdata  (wb_wdata),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_op0   (out_op0),
        .out_op1   (out_op1),
        .out_tag   (out_tag)
    );

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic req(input logic [4:0] a0, input logic [4:0] a1, input logic [7:0] t);
        in_valid  = 1'b1;
        in_r0addr = a0;
        in_r1addr = a1;
        in_tag    = t;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
        wb_wena = 1'b0; wb_waddr = '0; wb_wdata = '0;
        req(5'd3, 5'd7, 8'h99);
        #1;
        check_eq("ready_in_reset", in_ready, 1);
        step();
        step();
        check_eq("ready_in_reset2", in_ready, 1);
        rst = 1'b0;
        in_valid = 1'b0;
        #1;
        check_eq("rst_valid", out_valid, 0);
        check_eq("rst_op0", out_op0, 0);
        check_eq("rst_op1", out_op1, 0);
        check_eq("rst_tag", out_tag, 0);

        // First accept returns register-file values
        req(5'd3, 5'd7, 8'h11);
        step();
        in_valid = 1'b0;
        check_eq("first_valid", out_valid, 1);
        check_eq("first_op0", out_op0, 32'h33);
        check_eq("first_op1", out_op1, 32'h77);
        check_eq("first_tag", out_tag, 8'h11);
        out_ready = 1'b1;
        step();
        check_eq("drain_valid", out_valid, 0);
        check_eq("drain_keep_op0", out_op0, 32'h33);

        // Forward at accept
        req(5'd5, 5'd3, 8'h02);
        wb_wena = 1'b1; wb_waddr = 5'd5; wb_wdata = 32'hAA;
        step();
        wb_wena = 1'b0; in_valid = 1'b0;
        check_eq("fwd_op0", out_op0, BYP ? 32'hAA : 32'h11);
        check_eq("fwd_op1", out_op1, 32'h33);
        step();

        // Zero register never forwarded, never reads rf
        req(5'd0, 5'd0, 8'h03);
        wb_wena = 1'b1; wb_waddr = 5'd0; wb_wdata = 32'hFF;
        step();
        wb_wena = 1'b0; in_valid = 1'b0;
        check_eq("zero_op0", out_op0, 0);
        check_eq("zero_op1", out_op1, 0);
        step();

        // Hold with snooped write to src1
        out_ready = 1'b0;
        req(5'd3, 5'd7, 8'h5A);
        step();
        req(5'd5, 5'd5, 8'hEE);
        #1;
        check_eq("hold_ready_c1", in_ready, 0);
        step();
        check_eq("hold_op1_c1", out_op1, 32'h77);
        wb_wena = 1'b1; wb_waddr = 5'd7; wb_wdata = 32'h1234;
        #1;
        check_eq("hold_ready_c2", in_ready, 0);
        step();
        wb_wena = 1'b0;
        check_eq("hold_op1_c3", out_op1, BYP ? 32'h1234 : 32'h77);
        check_eq("hold_op0_c3", out_op0, 32'h33);
        check_eq("hold_tag_c3", out_tag, 8'h5A);
        check_eq("hold_ready_c3", in_ready, 0);
        in_valid = 1'b0;
        step();
        check_eq("hold_op1_c4", out_op1, BYP ? 32'h1234 : 32'h77);
        check_eq("hold_valid_c4", out_valid, 1);
        out_ready = 1'b1;
        step();
        check_eq("hold_drain", out_valid, 0);

        // Back-to-back, one per cycle
        exp_op0[1] = 32'h101; exp_op0[2] = 32'h102;
        exp_op0[3] = 32'h33;  exp_op0[4] = 32'h104;
        for (int i = 1; i <= 4; i++) begin
            req(5'(i), 5'd0, 8'(i));
            step();
            check_eq("b2b_valid", out_valid, 1);
            check_eq("b2b_tag", out_tag, 8'(i));
            check_eq("b2b_op0", out_op0, exp_op0[i]);
        end
        in_valid = 1'b0;
        step();
        check_eq("b2b_end", out_valid, 0);

        // Flush kills the held entry and blocks the pending request
        out_ready = 1'b0;
        req(5'd1, 5'd2, 8'h66);
        step();
        check_eq("flush_pre_valid", out_valid, 1);
        flush = 1'b1;
        req(5'd2, 5'd1, 8'h77);
        #1;
        check_eq("flush_ready", in_ready, 0);
        step();
        check_eq("flush_valid", out_valid, 0);
        flush = 1'b0;
        #1;
        check_eq("post_flush_ready", in_ready, 1);
        step();
        in_valid = 1'b0;
        check_eq("post_flush_valid", out_valid, 1);
        check_eq("post_flush_tag", out_tag, 8'h77);
        check_eq("post_flush_op0", out_op0, 32'h102);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
